pu_wb_sram_arbiter: RTL and testbench
=====================================

# pu_wb_sram_arbiter

Parametrised weight-buffer SRAM arbiter for the processing unit. It serves `NUM_CH` input-channel lanes, each with three requesters (index, unique-weight and repetition buffer), over one shared WB SRAM read port. Grants are round-robin or fixed-priority, and each lane's region is offset by a per-channel stride. It sits between the per-channel weight buffers and the WB SRAM, and replaces the fixed-size, fixed-priority WB SRAM controller.

## Interface
Parameters:
- `NUM_CH`, default 4: number of channel lanes. There are `NR = 3*NUM_CH` requesters. Requester `r = 3*ch + type`, where type 0 is idx, 1 is unique and 2 is repetition.
- `WORD_W`, default `` `WEIGHT_SRAM_LEN ``: SRAM word width.
- `ADDR_W`, default 32: address and counter width.

Ports:
- `clock`, in, 1: single clock. All logic is on the rising edge.
- `reset`, in, 1: reset is synchronous and active-high.
- `rr_en`, in, 1: 1 selects round-robin, 0 selects fixed priority (lowest `r` wins).
- `flush`, in, 1: synchronous abort of any transaction in flight.
- `ch_stride`, in, `ADDR_W`: address offset between consecutive channel lanes.
- `idx_start`, `unique_start`, `rep_start`, in, `ADDR_W` each: region base per requester type.
- `req_read`, in, `NR`: level request per requester.
- `word_counter`, in, `NR x ADDR_W`: word offset per requester.
- `word_ready`, out, `NR`: one-cycle pulse to the granted requester when its word is on `word_data`.
- `word_data`, out, `WORD_W`: registered read data, broadcast to all requesters.
- `SRAM_read`, out, 1: read strobe, held until the SRAM accepts.
- `SRAM_address`, out, `ADDR_W`: read address, stable while `SRAM_read` is high.
- `SRAM_ready`, in, 1: the SRAM returns data on `SRAM_in` in this cycle.
- `SRAM_in`, in, `WORD_W`: SRAM read data.
- `busy`, out, 1: high in every state except IDLE.

## Operation
The arbiter is a state machine with three states: IDLE, WAIT and DONE.
- **IDLE**
  - If any `req_read` bit is high, select the grant `g`.
    - Round-robin (`rr_en=1`): the first requesting index scanning upward from `last_grant+1`, wrapping modulo `NR`.
    - Fixed priority (`rr_en=0`): the lowest requesting index.
  - Register `g`.
  - Register `SRAM_address = base(type(g)) + ch(g)*ch_stride + word_counter[g]`. Arithmetic is modulo 2^`ADDR_W`; overflow and the product are truncated.
  - Go to WAIT.
  - `req_read` and `word_counter` are sampled only at this grant cycle. Later changes do not affect the transaction in flight.
- **WAIT**
  - Hold `SRAM_read=1` with a constant `SRAM_address`.
  - When `SRAM_ready=1`, capture `SRAM_in` into `word_data`, drop `SRAM_read`, and go to DONE.
  - `SRAM_ready` is ignored outside WAIT.
- **DONE**
  - Pulse `word_ready[g]=1` for exactly one cycle.
  - Set `last_grant = g`.
  - Go to IDLE.
  - `last_grant` updates in both modes.
- **Dropped request:** if the granted requester drops `req_read` during WAIT, the transaction still completes and `word_ready[g]` still pulses.
- **Request still high:** if `req_read[g]` is still high in the IDLE cycle after DONE, it is treated as a new request.
- **Flush:** `flush=1` in any state forces IDLE next cycle.
  - `SRAM_read` goes to 0 and no `word_ready` is issued.
  - `last_grant` is kept.
  - `word_data` is kept.
  - `flush` has priority over `SRAM_ready` in the same cycle.
- **Reset:**
  - Reset overrides `flush` and all other inputs.
  - State returns to IDLE.
  - `SRAM_read`, `SRAM_address`, `word_ready`, `word_data` and `busy` all return to 0.
  - `last_grant` returns to `NR-1`, so the first round-robin grant is requester 0.
- **At most one outstanding read.** `word_ready` is one-hot or zero in every cycle.

## Timing
- **Latency:** with `req_read` high in IDLE at cycle t:
  - `SRAM_read` and `SRAM_address` are valid at t+1.
  - With `SRAM_ready` high at t+1+k, `word_data` and `word_ready` are valid at t+2+k.
  - Earliest next grant: decided at t+3+k, with `SRAM_read` at t+4+k.
- **Throughput:** at most one word per 3 cycles (with `k=0`).
- **Outputs:** all outputs are registered. There is no combinational path from any input to any output.
- **Fairness:** with all `NR` requesters held high in round-robin mode, each is served exactly once in every `NR` consecutive grants.

## Test plan
- **Reset and single request:** after reset, `NUM_CH=4`, `idx_start=0x100`, `ch_stride=0x40`, `word_counter[3]=5`, `req_read[3]` held high, `SRAM_ready` high one cycle after `SRAM_read` rises, `SRAM_in=0xA5`.
  - `SRAM_address=0x145` one cycle after the request.
  - `word_ready[3]` pulses 2 cycles after that, with `word_data=0xA5`.
- **Round-robin:** requesters 0, 4 and 11 held high, `rr_en=1` → grant order 0, 4, 11, 0, 4. Each `word_ready` is one-hot.
- **Fixed priority:** same stimulus with `rr_en=0` → requester 0 is granted repeatedly; 4 and 11 are never granted while 0 remains high.
- **SRAM stall:** `SRAM_ready` low for 5 cycles during WAIT → `SRAM_read` and `SRAM_address` stay constant for 6 cycles; `word_ready` fires once, exactly 1 cycle after `SRAM_ready`.
- **Flush and ready together:** `flush` and `SRAM_ready` high in the same WAIT cycle → no `word_ready`, `SRAM_read=0` next cycle, `busy=0` next cycle, and a retained request is re-granted from IDLE.
- **Wrap and reset mid-transaction:**
  - `rep_start=0xFFFF_FFF0`, `word_counter=0x20` → `SRAM_address=0x10`.
  - Asserting `reset` while in WAIT → all outputs 0 on the next cycle, and the next grant is requester 0.

Source files
------------

// File: rtl/pu_wb_sram_arbiter.sv
// Weight-buffer SRAM arbiter: NUM_CH lanes x {idx, unique, rep} requesters
// share one SRAM read port, with round-robin or fixed-priority grant selection.
`ifndef WEIGHT_SRAM_LEN
`define WEIGHT_SRAM_LEN 64
`endif

module pu_wb_sram_arbiter #(
  parameter int NUM_CH = 4,
  parameter int WORD_W = `WEIGHT_SRAM_LEN,
  parameter int ADDR_W = 32,
  localparam int NR = 3 * NUM_CH
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rr_en,
  input  logic                 flush,
  input  logic [ADDR_W-1:0]    ch_stride,
  input  logic [ADDR_W-1:0]    idx_start,
  input  logic [ADDR_W-1:0]    unique_start,
  input  logic [ADDR_W-1:0]    rep_start,
  input  logic [NR-1:0]        req_read,
  input  logic [NR*ADDR_W-1:0] word_counter,
  output logic [NR-1:0]        word_ready,
  output logic [WORD_W-1:0]    word_data,
  output logic                 SRAM_read,
  output logic [ADDR_W-1:0]    SRAM_address,
  input  logic                 SRAM_ready,
  input  logic [WORD_W-1:0]    SRAM_in,
  output logic                 busy
);

  localparam int GW = (NR > 1) ? $clog2(NR) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

  state_t            state;
  logic [GW-1:0]     grant;
  logic [GW-1:0]     last_grant;
  logic              grant_found;
  logic [GW-1:0]     grant_sel;
  logic [ADDR_W-1:0] addr_sel;
  logic [ADDR_W-1:0] ch_off;

  // Round-robin scans upward from last_grant+1; fixed priority scans from 0.
  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_sel   = '0;
    for (int off = 1; off <= NR; off++) begin
      idx = rr_en ? ((int'(last_grant) + off) % NR) : (off - 1);
      if (!grant_found && req_read[idx]) begin
        grant_found = 1'b1;
        grant_sel   = GW'(idx);
      end
    end
  end

  // Region base by requester type, plus lane offset and word offset (mod 2^ADDR_W).
  always_comb begin
    addr_sel = '0;
    ch_off   = '0;
    for (int r = 0; r < NR; r++) begin
      if (grant_sel == GW'(r)) begin
        ch_off = ADDR_W'(r / 3) * ch_stride;
        case (r % 3)
          0:       addr_sel = idx_start    + ch_off + word_counter[r*ADDR_W +: ADDR_W];
          1:       addr_sel = unique_start + ch_off + word_counter[r*ADDR_W +: ADDR_W];
          default: addr_sel = rep_start    + ch_off + word_counter[r*ADDR_W +: ADDR_W];
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      grant        <= '0;
      last_grant   <= GW'(NR - 1);
      SRAM_read    <= 1'b0;
      SRAM_address <= '0;
      word_ready   <= '0;
      word_data    <= '0;
      busy         <= 1'b0;
    end else if (flush) begin
      // Abort: last_grant and word_data deliberately untouched.
      state      <= ST_IDLE;
      SRAM_read  <= 1'b0;
      word_ready <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_found) begin
            grant        <= grant_sel;
            SRAM_address <= addr_sel;
            SRAM_read    <= 1'b1;
            busy         <= 1'b1;
            state        <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (SRAM_ready) begin
            word_data  <= SRAM_in;
            SRAM_read  <= 1'b0;
            word_ready <= NR'(1) << grant;
            state      <= ST_DONE;
          end
        end
        ST_DONE: begin
          word_ready <= '0;
          last_grant <= grant;
          busy       <= 1'b0;
          state      <= ST_IDLE;
        end
        default: begin
          state     <= ST_IDLE;
          SRAM_read <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pu_wb_sram_arbiter.sv
// Scoreboard bench for pu_wb_sram_arbiter: stimulus pushes expected reads and
// grants, independent monitors pop and compare on SRAM_read rise / word_ready.
module tb_pu_wb_sram_arbiter;
  localparam int NUM_CH = 4;
  localparam int NR = 3 * NUM_CH;
  localparam int AW = 32;
  localparam int WW = 16;

  logic              clock = 1'b0;
  logic              reset, rr_en, flush;
  logic [AW-1:0]     ch_stride, idx_start, unique_start, rep_start;
  logic [NR-1:0]     req_read;
  logic [NR*AW-1:0]  word_counter;
  logic [NR-1:0]     word_ready;
  logic [WW-1:0]     word_data;
  logic              SRAM_read;
  logic [AW-1:0]     SRAM_address;
  logic              SRAM_ready = 1'b0;
  logic [WW-1:0]     SRAM_in = '0;
  logic              busy;

  pu_wb_sram_arbiter #(.NUM_CH(NUM_CH), .WORD_W(WW), .ADDR_W(AW)) dut (
    .clock(clock), .reset(reset), .rr_en(rr_en), .flush(flush),
    .ch_stride(ch_stride), .idx_start(idx_start), .unique_start(unique_start),
    .rep_start(rep_start), .req_read(req_read), .word_counter(word_counter),
    .word_ready(word_ready), .word_data(word_data), .SRAM_read(SRAM_read),
    .SRAM_address(SRAM_address), .SRAM_ready(SRAM_ready), .SRAM_in(SRAM_in),
    .busy(busy)
  );

  always #5 clock = ~clock;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic chk_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // SRAM stub data is a fixed function of the address.
  function automatic logic [WW-1:0] sram_f(input logic [AW-1:0] a);
    return {8'h00, a[7:0] ^ 8'hE0};
  endfunction

  logic [AW-1:0] addr_q[$];
  int            grant_q[$];
  logic [AW-1:0] gaddr_q[$];

  task automatic expect_read(input logic [AW-1:0] a);
    addr_q.push_back(a);
  endtask

  task automatic expect_txn(input int r, input logic [AW-1:0] a);
    addr_q.push_back(a);
    grant_q.push_back(r);
    gaddr_q.push_back(a);
  endtask

  // SRAM responder: asserts SRAM_ready after 'stall' cycles of SRAM_read.
  int stall = 0;
  int scnt  = 0;
  always @(negedge clock) begin
    SRAM_ready = 1'b0;
    if (SRAM_read) begin
      if (scnt >= stall) begin
        SRAM_ready = 1'b1;
        scnt = 0;
      end else scnt++;
    end else scnt = 0;
    SRAM_in = sram_f(SRAM_address);
  end

  logic          prev_read = 1'b0;
  logic [AW-1:0] m_addr;
  int            m_r;
  logic [NR-1:0] m_onehot;
  always @(negedge clock) begin
    if (!reset) begin
      if (SRAM_read && !prev_read) begin
        chk_eq("read_expected", addr_q.size() != 0, 1);
        if (addr_q.size() != 0) begin
          m_addr = addr_q.pop_front();
          chk_eq("sram_address", SRAM_address, m_addr);
        end
      end
      if (word_ready != '0) begin
        chk_eq("ready_expected", grant_q.size() != 0, 1);
        if (grant_q.size() != 0) begin
          m_r = grant_q.pop_front();
          m_addr = gaddr_q.pop_front();
          m_onehot = '0;
          m_onehot[m_r] = 1'b1;
          chk_eq("word_ready", word_ready, m_onehot);
          chk_eq("word_data", word_data, sram_f(m_addr));
        end
      end
    end
    prev_read = SRAM_read;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic wait_ready(input int n);
    int got = 0;
    int t = 0;
    while (got < n && t < 300) begin
      @(negedge clock);
      t++;
      if (word_ready != '0) got++;
    end
    chk_eq("ready_count", got, n);
  endtask

  task automatic wait_read();
    int t = 0;
    do begin
      @(negedge clock);
      t++;
    end while (!SRAM_read && t < 50);
    chk_eq("read_seen", SRAM_read, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, n_same;
    logic [AW-1:0] a0;
    reset = 1'b1; rr_en = 1'b1; flush = 1'b0;
    ch_stride = 32'h40; idx_start = 32'h100; unique_start = 32'h200; rep_start = 32'h300;
    req_read = '0;
    for (int r = 0; r < NR; r++) word_counter[r*AW +: AW] = AW'(r + 2);
    tick(3);
    chk_eq("rst_sram_read", SRAM_read, 0);
    chk_eq("rst_sram_address", SRAM_address, 0);
    chk_eq("rst_word_ready", word_ready, 0);
    chk_eq("rst_word_data", word_data, 0);
    chk_eq("rst_busy", busy, 0);
    reset = 1'b0;
    tick(1);

    // Single request with one-cycle SRAM latency.
    stall = 1;
    expect_txn(3, 32'h145);
    req_read[3] = 1'b1;
    tick(1);
    chk_eq("t1_read", SRAM_read, 1);
    chk_eq("t1_addr", SRAM_address, 32'h145);
    chk_eq("t1_busy", busy, 1);
    tick(2);
    chk_eq("t1_ready", word_ready, 12'h008);
    chk_eq("t1_data", word_data, 16'h00A5);
    req_read = '0;
    tick(2);

    // Round-robin over 0, 4, 11.
    do_reset();
    stall = 0;
    expect_txn(0, 32'h102); expect_txn(4, 32'h246); expect_txn(11, 32'h3CD);
    expect_txn(0, 32'h102); expect_txn(4, 32'h246);
    req_read = 12'h811;
    wait_ready(5);
    req_read = '0;
    tick(3);

    // Fixed priority: 0 wins every time.
    rr_en = 1'b0;
    expect_txn(0, 32'h102); expect_txn(0, 32'h102); expect_txn(0, 32'h102);
    req_read = 12'h811;
    wait_ready(3);
    req_read = '0;
    rr_en = 1'b1;
    tick(3);

    // Five-cycle stall; request dropped during WAIT must still complete.
    stall = 5;
    expect_txn(3, 32'h145);
    req_read[3] = 1'b1;
    wait_read();
    req_read = '0;
    a0 = SRAM_address;
    n = 0; n_same = 0;
    while (SRAM_read && n < 50) begin
      if (SRAM_address == a0) n_same++;
      n++;
      @(negedge clock);
    end
    chk_eq("stall_read_cycles", n, 6);
    chk_eq("stall_addr_stable", n_same, 6);
    chk_eq("stall_ready_timing", word_ready, 12'h008);
    tick(1);
    chk_eq("stall_single_pulse", word_ready, 0);
    stall = 0;
    tick(2);

    // Flush coincident with SRAM_ready, retained request re-granted.
    expect_read(32'h203);
    expect_txn(1, 32'h203);
    req_read[1] = 1'b1;
    wait_read();
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    chk_eq("flush_read", SRAM_read, 0);
    chk_eq("flush_busy", busy, 0);
    chk_eq("flush_no_ready", word_ready, 0);
    wait_ready(1);
    req_read = '0;
    tick(3);

    // Address wrap modulo 2^32.
    rep_start = 32'hFFFF_FFF0;
    word_counter[2*AW +: AW] = 32'h20;
    expect_txn(2, 32'h10);
    req_read[2] = 1'b1;
    wait_ready(1);
    req_read = '0;
    tick(2);

    // Reset during WAIT, then the first round-robin grant must be 0.
    stall = 20;
    expect_read(32'h37);
    req_read[5] = 1'b1;
    wait_read();
    tick(2);
    reset = 1'b1;
    tick(1);
    chk_eq("midrst_read", SRAM_read, 0);
    chk_eq("midrst_addr", SRAM_address, 0);
    chk_eq("midrst_ready", word_ready, 0);
    chk_eq("midrst_data", word_data, 0);
    chk_eq("midrst_busy", busy, 0);
    reset = 1'b0;
    stall = 0;
    expect_txn(0, 32'h102);
    expect_txn(5, 32'h37);
    req_read = 12'h021;
    wait_ready(2);
    req_read = '0;
    tick(4);

    chk_eq("addr_q_empty", addr_q.size(), 0);
    chk_eq("grant_q_empty", grant_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
